// File: rtl/mcu_raster_out.sv
// mcu_raster_out: reorders 4:2:0 MCU block rows into raster pixels through a
// double-buffered 16-line stripe store, adding back the JPEG level shift.
module mcu_raster_out #(
    parameter int            SENSOR_X_SIZE = 720,
    parameter int            SENSOR_Y_SIZE = 720,
    parameter int            DW            = 8,
    parameter logic [DW-1:0] JPEG_BIAS     = 8'd128,
    localparam int           XW            = $clog2(SENSOR_X_SIZE),
    localparam int           YW            = $clog2(SENSOR_Y_SIZE)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [7:0][DW-1:0]  blk_in,
    input  logic                blk_in_valid,
    output logic                blk_in_hold,
    input  logic [XW-1:0]       x_size_m1,
    input  logic [YW-1:0]       y_size_m1,
    output logic [2:0][DW-1:0]  yuv_out,
    output logic [2:0]          yuv_out_valid,
    input  logic                yuv_out_hold,
    output logic [XW-1:0]       yuv_out_pixel_count,
    output logic [YW-1:0]       yuv_out_line_count,
    output logic                eof_out
);
    localparam int LAW = XW + 2;   // bank, 4-bit line, 8-sample word index
    localparam int CAW = XW;       // bank, 3-bit chroma line, chroma word index

    typedef logic [7:0][DW-1:0] row_t;
    typedef enum logic [1:0] {IDLE, EMIT, DRAIN} state_t;

    row_t mem_y [2**LAW];
    row_t mem_u [2**CAW];
    row_t mem_v [2**CAW];
    row_t y_word, u_word, v_word;

    logic [2:0]    wr_r, wr_m;
    logic [XW-5:0] wr_bc;
    logic [YW-5:0] wr_s;
    logic          wbank, rbank;
    logic [1:0]    full_reg, full_next;
    logic          wr_en, wr_last_bc, wr_last_s, stripe_done;

    state_t        state_reg, state_next;
    logic [XW-1:0] rx, x1;
    logic [3:0]    rl, rl_max;
    logic [YW-5:0] rs;
    logic [YW-1:0] l1;
    logic          rd_last_s, issue_last, advance, rd_en, clear;
    logic          v1, sl1, eof1, last_out, uv1;

    logic [LAW-1:0] wy_addr, ry_addr;
    logic [CAW-1:0] wc_addr, rc_addr;

    assign blk_in_hold = full_reg[wbank];
    assign wr_en       = blk_in_valid & ~blk_in_hold;
    assign wr_last_bc  = (wr_bc == x_size_m1[XW-1:4]);
    assign wr_last_s   = (wr_s == y_size_m1[YW-1:4]);
    assign stripe_done = wr_en && (wr_r == 3'd7) && (wr_m == 3'd5) && wr_last_bc;

    // Luma blocks 0..3 tile the macroblock as {row half, column half}.
    assign wy_addr = {wbank, wr_m[1], wr_r, wr_bc, wr_m[0]};
    assign wc_addr = {wbank, wr_r, wr_bc};
    assign ry_addr = {rbank, rl, rx[XW-1:3]};
    assign rc_addr = {rbank, rl[3:1], rx[XW-1:4]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_r  <= '0;
            wr_m  <= '0;
            wr_bc <= '0;
            wr_s  <= '0;
            wbank <= 1'b0;
        end else if (wr_en) begin
            if (wr_r != 3'd7) begin
                wr_r <= wr_r + 3'd1;
            end else begin
                wr_r <= '0;
                if (wr_m != 3'd5) begin
                    wr_m <= wr_m + 3'd1;
                end else begin
                    wr_m <= '0;
                    if (!wr_last_bc) begin
                        wr_bc <= wr_bc + 1'b1;
                    end else begin
                        wr_bc <= '0;
                        wbank <= ~wbank;
                        wr_s  <= wr_last_s ? '0 : wr_s + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !wr_m[2]) mem_y[wy_addr] <= blk_in;
        if (rd_en) y_word <= mem_y[ry_addr];
    end

    always_ff @(posedge clk) begin
        if (wr_en && wr_m == 3'd4) mem_u[wc_addr] <= blk_in;
        if (rd_en) u_word <= mem_u[rc_addr];
    end

    always_ff @(posedge clk) begin
        if (wr_en && wr_m == 3'd5) mem_v[wc_addr] <= blk_in;
        if (rd_en) v_word <= mem_v[rc_addr];
    end

    // The whole read pipeline freezes while a presented pixel is held.
    assign advance    = ~(|yuv_out_valid) | ~yuv_out_hold;
    assign rd_last_s  = (rs == y_size_m1[YW-1:4]);
    assign rl_max     = rd_last_s ? y_size_m1[3:0] : 4'd15;
    assign issue_last = (rx == x_size_m1) && (rl == rl_max);
    assign clear      = (|yuv_out_valid) & ~yuv_out_hold & last_out;
    assign uv1        = v1 & ~x1[0] & ~l1[0];

    always_comb begin
        full_next = full_reg;
        if (clear)       full_next[rbank] = 1'b0;
        if (stripe_done) full_next[wbank] = 1'b1;
    end

    always_comb begin
        state_next = state_reg;
        rd_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (advance && full_reg[rbank]) begin
                    rd_en      = 1'b1;
                    state_next = issue_last ? DRAIN : EMIT;
                end
            end
            EMIT: begin
                if (advance) begin
                    rd_en = 1'b1;
                    if (issue_last) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (clear) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            full_reg  <= '0;
            rbank     <= 1'b0;
            rx        <= '0;
            rl        <= '0;
            rs        <= '0;
        end else begin
            state_reg <= state_next;
            full_reg  <= full_next;
            if (clear) rbank <= ~rbank;
            if (rd_en) begin
                if (issue_last) begin
                    rx <= '0;
                    rl <= '0;
                    rs <= rd_last_s ? '0 : rs + 1'b1;
                end else if (rx == x_size_m1) begin
                    rx <= '0;
                    rl <= rl + 4'd1;
                end else begin
                    rx <= rx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1                  <= 1'b0;
            sl1                 <= 1'b0;
            eof1                <= 1'b0;
            x1                  <= '0;
            l1                  <= '0;
            yuv_out             <= '0;
            yuv_out_valid       <= '0;
            yuv_out_pixel_count <= '0;
            yuv_out_line_count  <= '0;
            eof_out             <= 1'b0;
            last_out            <= 1'b0;
        end else if (advance) begin
            v1                  <= rd_en;
            sl1                 <= issue_last;
            eof1                <= issue_last & rd_last_s;
            x1                  <= rx;
            l1                  <= {rs, rl};
            yuv_out[0]          <= y_word[x1[2:0]] + JPEG_BIAS;
            yuv_out[1]          <= u_word[x1[3:1]] + JPEG_BIAS;
            yuv_out[2]          <= v_word[x1[3:1]] + JPEG_BIAS;
            yuv_out_valid       <= {uv1, uv1, v1};
            yuv_out_pixel_count <= x1;
            yuv_out_line_count  <= l1;
            eof_out             <= v1 & eof1;
            last_out            <= v1 & sl1;
        end
    end
endmodule

// File: tb/tb_mcu_raster_out.sv
// tb_mcu_raster_out: feeds MCU-ordered rows of a synthetic image and checks the
// raster stream against an expected-pixel queue built from the same image.
module tb_mcu_raster_out;
    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [7:0][7:0]  blk_in = '0;
    logic             blk_in_valid = 1'b0;
    logic             blk_in_hold;
    logic [9:0]       x_size_m1 = 10'd15;
    logic [9:0]       y_size_m1 = 10'd15;
    logic [2:0][7:0]  yuv_out;
    logic [2:0]       yuv_out_valid;
    logic             yuv_out_hold = 1'b0;
    logic [9:0]       yuv_out_pixel_count;
    logic [9:0]       yuv_out_line_count;
    logic             eof_out;

    always #5 clk = ~clk;

    mcu_raster_out dut (
        .clk                 (clk),
        .resetn              (resetn),
        .blk_in              (blk_in),
        .blk_in_valid        (blk_in_valid),
        .blk_in_hold         (blk_in_hold),
        .x_size_m1           (x_size_m1),
        .y_size_m1           (y_size_m1),
        .yuv_out             (yuv_out),
        .yuv_out_valid       (yuv_out_valid),
        .yuv_out_hold        (yuv_out_hold),
        .yuv_out_pixel_count (yuv_out_pixel_count),
        .yuv_out_line_count  (yuv_out_line_count),
        .eof_out             (eof_out)
    );

    typedef struct packed {
        logic [2:0] vld;
        logic [9:0] x;
        logic [9:0] l;
        logic       eof;
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
    } pix_t;

    pix_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          xfer_count = 0;
    int          n_out = 0;
    logic        rel_arm = 1'b0;
    logic        rel_pending = 1'b0;
    logic        stall_prev = 1'b0;
    logic [47:0] snap_prev = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stored (level-shifted) sample values of the synthetic image.
    function automatic logic [7:0] ys(input int seed, input int x, input int y);
        if (seed == 0) return 8'(x + 16 * y - 128);
        return 8'(x * 3 + y * 5 + seed * 17);
    endfunction

    function automatic logic [7:0] us(input int seed, input int cx, input int cy);
        if (seed == 0) return 8'd0;
        return 8'(cx * 7 + cy * 11 + seed);
    endfunction

    function automatic logic [7:0] vs(input int seed, input int cx, input int cy);
        if (seed == 0) return 8'd0;
        return 8'(cx * 13 + cy * 3 + seed * 5 + 99);
    endfunction

    task automatic push_frame(input int seed, input int xm1, input int ym1);
        pix_t p;
        for (int l = 0; l <= ym1; l++) begin
            for (int x = 0; x <= xm1; x++) begin
                p.x   = 10'(x);
                p.l   = 10'(l);
                p.eof = (x == xm1) && (l == ym1);
                p.vld = ((x % 2 == 0) && (l % 2 == 0)) ? 3'b111 : 3'b001;
                p.y   = ys(seed, x, l) + 8'd128;
                p.u   = us(seed, x / 2, l / 2) + 8'd128;
                p.v   = vs(seed, x / 2, l / 2) + 8'd128;
                sb.push_back(p);
            end
        end
    endtask

    task automatic send_row(input logic [7:0][7:0] row);
        int n = 0;
        blk_in       = row;
        blk_in_valid = 1'b1;
        @(negedge clk);
        while (blk_in_hold && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("feed_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        blk_in_valid = 1'b0;
        xfer_count++;
    endtask

    task automatic feed_frame(input int seed, input int xm1, input int ym1, input int maxrows);
        logic [7:0][7:0] row;
        int sent = 0;
        for (int s = 0; s <= ym1 / 16; s++)
            for (int bc = 0; bc <= xm1 / 16; bc++)
                for (int m = 0; m < 6; m++)
                    for (int r = 0; r < 8; r++) begin
                        if (maxrows >= 0 && sent >= maxrows) return;
                        for (int i = 0; i < 8; i++) begin
                            if (m < 4)       row[i] = ys(seed, bc * 16 + (m % 2) * 8 + i, s * 16 + (m / 2) * 8 + r);
                            else if (m == 4) row[i] = us(seed, bc * 8 + i, s * 8 + r);
                            else             row[i] = vs(seed, bc * 8 + i, s * 8 + r);
                        end
                        send_row(row);
                        sent++;
                    end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic run_frame(input int seed, input int xm1, input int ym1, input bit rnd_hold);
        bit hold_rnd;
        x_size_m1 = 10'(xm1);
        y_size_m1 = 10'(ym1);
        n_out     = 0;
        push_frame(seed, xm1, ym1);
        if (rnd_hold) begin
            hold_rnd = 1'b1;
            fork
                begin
                    feed_frame(seed, xm1, ym1, -1);
                    wait_drain("drain_rnd");
                    hold_rnd = 1'b0;
                end
                begin
                    while (hold_rnd) begin
                        @(posedge clk);
                        #1;
                        if (hold_rnd) yuv_out_hold = 1'($urandom_range(0, 1));
                    end
                    yuv_out_hold = 1'b0;
                end
            join
        end else begin
            feed_frame(seed, xm1, ym1, -1);
            wait_drain("drain");
        end
        check("pixel_count", 64'(n_out), 64'((xm1 + 1) * (ym1 + 1)));
    endtask

    always @(negedge clk) begin
        logic [47:0] cur;
        logic [47:0] obs;
        logic [47:0] exp;
        pix_t        e;
        cur = {yuv_out, yuv_out_valid, yuv_out_pixel_count, yuv_out_line_count, eof_out};
        if (!resetn) begin
            stall_prev  = 1'b0;
            rel_pending = 1'b0;
        end else begin
            if (rel_pending) begin
                check("hold_release", 64'(blk_in_hold), 64'd0);
                rel_pending = 1'b0;
            end
            if (stall_prev) check("hold_stable", 64'(cur), 64'(snap_prev));
            if (|yuv_out_valid && !yuv_out_hold) begin
                if (sb.size() == 0) begin
                    check("extra_pixel", 64'(cur), 64'd0);
                end else begin
                    e   = sb.pop_front();
                    obs = {yuv_out_valid, yuv_out_pixel_count, yuv_out_line_count, eof_out, yuv_out[0],
                           yuv_out_valid[1] ? yuv_out[1] : 8'd0, yuv_out_valid[2] ? yuv_out[2] : 8'd0};
                    exp = {e.vld, e.x, e.l, e.eof, e.y, e.vld[1] ? e.u : 8'd0, e.vld[2] ? e.v : 8'd0};
                    check("pixel", 64'(obs), 64'(exp));
                    n_out++;
                end
                if (rel_arm && yuv_out_pixel_count == 10'd31 && yuv_out_line_count == 10'd15) begin
                    check("hold_before_release", 64'(blk_in_hold), 64'd1);
                    rel_pending = 1'b1;
                end
            end
            stall_prev = |yuv_out_valid && yuv_out_hold;
            snap_prev  = cur;
        end
    end

    initial begin
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_blk_hold", 64'(blk_in_hold), 64'd0);
        check("rst_valid", 64'(yuv_out_valid), 64'd0);
        check("rst_yuv", 64'(yuv_out), 64'd0);
        check("rst_pixel_count", 64'(yuv_out_pixel_count), 64'd0);
        check("rst_line_count", 64'(yuv_out_line_count), 64'd0);
        check("rst_eof", 64'(eof_out), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // 16x16 ramp frame
        run_frame(0, 15, 15, 1'b0);

        // 32x32 with random output hold
        run_frame(1, 31, 31, 1'b1);

        // 20x18: padding columns and a two-line final stripe
        run_frame(2, 19, 17, 1'b0);

        // 32x32 with output held until both banks fill
        x_size_m1    = 10'd31;
        y_size_m1    = 10'd31;
        n_out        = 0;
        xfer_count   = 0;
        rel_arm      = 1'b1;
        yuv_out_hold = 1'b1;
        push_frame(3, 31, 31);
        fork
            feed_frame(3, 31, 31, -1);
            begin
                n = 0;
                while (!blk_in_hold && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                check("hold_rise_xfers", 64'(xfer_count), 64'd192);
                repeat (200) @(posedge clk);
                #1;
                yuv_out_hold = 1'b0;
            end
        join
        wait_drain("drain_held");
        check("pixel_count_held", 64'(n_out), 64'd1024);
        rel_arm = 1'b0;

        // Reset with one full stripe and a partial one stored
        x_size_m1    = 10'd15;
        y_size_m1    = 10'd15;
        yuv_out_hold = 1'b1;
        feed_frame(7, 15, 15, -1);
        feed_frame(8, 15, 15, 20);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_blk_hold", 64'(blk_in_hold), 64'd0);
        check("midrst_valid", 64'(yuv_out_valid), 64'd0);
        @(posedge clk);
        #1;
        yuv_out_hold = 1'b0;
        resetn       = 1'b1;
        @(posedge clk);
        #1;
        run_frame(0, 15, 15, 1'b0);

        // Two back-to-back 16x16 frames
        n_out = 0;
        push_frame(9, 15, 15);
        push_frame(10, 15, 15);
        feed_frame(9, 15, 15, -1);
        feed_frame(10, 15, 15, -1);
        wait_drain("drain_b2b");
        check("pixel_count_b2b", 64'(n_out), 64'd512);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
